pic_priority_resolver_n: RTL
============================

// Module: pic_priority_resolver_n
// PURPOSE
//  Clocked, parametrised successor of the 8259A priority resolver for NUM_IRQ request lines.
//  Picks the highest-priority unmasked request that may pre-empt in-service levels.
//  Supports fully-nested, automatic-rotation and specific-rotation priority, plus special mask mode.
//  Drives a held INT request with an explicit ack handshake. Sits between IRR/IMR/ISR and the control logic.
// PARAMETERS
//  NUM_IRQ   8                    number of request lines; legal 2..32
//  IDX_W     $clog2(NUM_IRQ)      width of every index port
// PORTS
//  clk          in   1        system clock; all state updates on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  irr_i        in   NUM_IRQ  interrupt request register
//  imr_i        in   NUM_IRQ  interrupt mask register; 1 = masked
//  isr_i        in   NUM_IRQ  in-service register
//  freeze_i     in   1        1 = no new request may be raised (INTA sequence in progress)
//  rot_mode_i   in   2        00 fixed, 01 auto-rotate on EOI, 10 specific (pointer via set_prio), 11 = 00
//  smm_i        in   1        special mask mode enable
//  eoi_i        in   1        one-cycle pulse: EOI for level eoi_idx_i
//  eoi_idx_i    in   IDX_W    level being ended
//  set_prio_i   in   1        one-cycle pulse: load lowest-priority pointer
//  set_prio_idx_i in IDX_W    new lowest-priority level
//  int_ack_i    in   1        one-cycle pulse: CPU acknowledges int_req_o
//  int_req_o    out  1        held request to CPU
//  int_idx_o    out  IDX_W    index of winning level; valid while int_req_o = 1
//  ack_valid_o  out  1        one-cycle pulse: acknowledged index on ack_idx_o
//  ack_idx_o    out  IDX_W    index latched at ack
//  spurious_o   out  1        one-cycle pulse with ack_valid_o when no candidate existed at ack
//  top_prio_o   out  IDX_W    current highest-priority level (lowest pointer + 1 mod NUM_IRQ)
// BEHAVIOUR
//  Reset: int_req_o=0, int_idx_o=0, ack_valid_o=0, ack_idx_o=0, spurious_o=0, lowest-prio pointer=NUM_IRQ-1 (top_prio_o=0), state IDLE.
//  Priority order: level (ptr+1+k) mod NUM_IRQ has rank k; rank 0 is highest. rot_mode 00/11 forces ptr=NUM_IRQ-1.
//  Candidates: cand = irr_i & ~imr_i.
//   Nested (smm_i=0): a candidate qualifies only if its rank < rank of highest-ranked isr_i bit. Empty ISR: all qualify.
//   SMM (smm_i=1): qualifying set = cand & ~isr_i; ISR rank is ignored.
//  Winner: qualifying bit of lowest rank (combinational), called win/win_valid.
//  FSM IDLE -> REQ: when win_valid & ~freeze_i; int_req_o rises the next cycle (1-cycle latency).
//  REQ: int_req_o=1; int_idx_o follows win each cycle, so a higher level arriving before ack takes over.
//   freeze_i does not drop a raised request.
//  REQ -> ACKED on int_ack_i: ack_valid_o pulses 1 cycle; ack_idx_o = win.
//   If win_valid=0 at ack: ack_idx_o = NUM_IRQ-1 and spurious_o=1 (8259A IR7 rule). int_req_o drops the same edge.
//  ACKED -> IDLE after exactly 1 cycle (lets ISR update); no request raised in ACKED.
//  int_ack_i outside REQ is ignored; no pulses.
//  Rotation: eoi_i with rot_mode 01 -> ptr <= eoi_idx_i. eoi_i in other modes does not move ptr.
//   set_prio_i with rot_mode 10 -> ptr <= set_prio_idx_i. set_prio_i in other modes is ignored.
//   Same-cycle eoi_i & set_prio_i: set_prio_i wins.
//   Pointer change takes effect for resolution the following cycle.
//  Index inputs >= NUM_IRQ (non power-of-2): ignored, no state change.
//  Mode change mid-REQ: resolution re-evaluates next cycle; FSM not disturbed.
//  rst_n low at any time: immediate return to reset values, including mid-REQ.
// STRUCTURE
//  Shared package pic_pkg: rot_mode enum (ROT_FIXED, ROT_AUTO, ROT_SPECIFIC); FSM state enum (ST_IDLE, ST_REQ, ST_ACKED).
//  Sub-module pic_rot_prio_enc: combinational rotate-by-ptr, find-first, un-rotate; instantiated twice (cand, isr).
//  Top holds FSM, pointer register, ack/spurious registers.
// TESTING
//  T1 fixed, imr=0, isr=0, irr=8'b1010_0000 -> int_req_o=1 one cycle later, int_idx_o=5; ack -> ack_idx_o=5.
//  T2 nested: isr=8'b0000_0100, irr=8'b0000_1010 -> win=1; irr=8'b0000_1000 only -> no int_req_o.
//  T3 auto-rotate: eoi idx 3 -> top_prio_o=4; irr=8'b0001_0001 -> int_idx_o=4.
//  T4 spurious: raise on irr[2], drop irr before ack -> ack_idx_o=7, spurious_o=1, state IDLE after 2 cycles.
//  T5 SMM: smm=1, isr=8'b0000_0001, irr=8'b0000_0011 -> win=1. Then freeze_i=1 with new irr -> no request until freeze_i=0.
//  T6 rst_n low mid-REQ -> int_req_o=0 asynchronously, top_prio_o=0.
//  NUM_IRQ=5 regression: set_prio idx 4 -> top_prio_o=0; idx 6 ignored.

Source files
------------

// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pic_pkg
// Description : Shared types and helpers for the parametrised 8259A-style
//               priority resolver (rotation modes, FSM states, modular rank).
// Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

  // Priority rotation mode; encoding 2'b11 is not named and behaves as fixed.
  typedef enum logic [1:0] {
    ROT_FIXED    = 2'b00,
    ROT_AUTO     = 2'b01,
    ROT_SPECIFIC = 2'b10
  } rot_mode_e;

  // Request handshake states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACKED = 2'd2
  } pic_state_e;

  // (a + b) mod n for operands whose sum never reaches 2n.
  function automatic int wrap_sum(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

  // Rank of level idx when ptr is the lowest-priority level (rank 0 = highest).
  function automatic int rank_of(input int idx, input int ptr, input int n);
    return wrap_sum(idx, n - 1 - ptr, n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pic_rot_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pic_rot_prio_enc
// Description : Rotating find-first. Scans levels starting just above the
//               lowest-priority pointer and returns the first set bit as an
//               absolute level index.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_rot_prio_enc
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] i_vec,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  int w_lvl;

  // Walk from lowest rank to highest so the last hit (rank 0 side) wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_lvl   = 0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      w_lvl = wrap_sum(int'(i_ptr) + 1, k, NUM_IRQ);
      if (i_vec[IDX_W'(w_lvl)]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(w_lvl);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pic_priority_resolver_n.sv
`default_nettype none
// ============================================================================
// Module      : pic_priority_resolver_n
// Description : Clocked NUM_IRQ-line priority resolver with fully-nested,
//               automatic and specific rotation, special mask mode and a held
//               INT request closed by an explicit acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_priority_resolver_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr_i,
  input  logic [NUM_IRQ-1:0] imr_i,
  input  logic [NUM_IRQ-1:0] isr_i,
  input  logic               freeze_i,
  input  logic [1:0]         rot_mode_i,
  input  logic               smm_i,
  input  logic               eoi_i,
  input  logic [IDX_W-1:0]   eoi_idx_i,
  input  logic               set_prio_i,
  input  logic [IDX_W-1:0]   set_prio_idx_i,
  input  logic               int_ack_i,
  output logic               int_req_o,
  output logic [IDX_W-1:0]   int_idx_o,
  output logic               ack_valid_o,
  output logic [IDX_W-1:0]   ack_idx_o,
  output logic               spurious_o,
  output logic [IDX_W-1:0]   top_prio_o
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_IRQ - 1);
  localparam logic [IDX_W:0]   c_num_ext  = (IDX_W + 1)'(NUM_IRQ);

  rot_mode_e          w_mode;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_eff;
  logic [NUM_IRQ-1:0] w_cand;
  logic [NUM_IRQ-1:0] w_enc_in;
  logic               w_cand_found;
  logic [IDX_W-1:0]   w_cand_idx;
  logic               w_isr_found;
  logic [IDX_W-1:0]   w_isr_idx;
  int                 w_cand_rank;
  int                 w_isr_rank;
  logic               w_win_valid;
  logic               w_eoi_idx_ok;
  logic               w_set_idx_ok;
  pic_state_e         r_state;

  assign w_mode = rot_mode_e'(rot_mode_i);

  // Fixed mode (and the unnamed 2'b11) pins the pointer so level 0 is on top;
  // the stored pointer survives so returning to a rotating mode resumes it.
  always_comb begin
    w_ptr_eff = c_last_idx;
    if (w_mode == ROT_AUTO || w_mode == ROT_SPECIFIC) w_ptr_eff = r_ptr;
  end

  assign top_prio_o = (w_ptr_eff == c_last_idx) ? '0 : w_ptr_eff + 1'b1;

  // In special mask mode in-service levels are simply removed from the pool.
  assign w_cand   = irr_i & ~imr_i;
  assign w_enc_in = smm_i ? (w_cand & ~isr_i) : w_cand;

  pic_rot_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_enc_cand (
    .i_vec   (w_enc_in),
    .i_ptr   (w_ptr_eff),
    .o_found (w_cand_found),
    .o_idx   (w_cand_idx)
  );

  pic_rot_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_enc_isr (
    .i_vec   (isr_i),
    .i_ptr   (w_ptr_eff),
    .o_found (w_isr_found),
    .o_idx   (w_isr_idx)
  );

  // Ranks of the best candidate and of the highest in-service level.
  always_comb begin
    w_cand_rank = rank_of(int'(w_cand_idx), int'(w_ptr_eff), NUM_IRQ);
    w_isr_rank  = rank_of(int'(w_isr_idx), int'(w_ptr_eff), NUM_IRQ);
  end

  // Only the best candidate needs checking: if it cannot pre-empt, none can.
  assign w_win_valid = w_cand_found &
                       (smm_i | ~w_isr_found | (w_cand_rank < w_isr_rank));

  assign w_eoi_idx_ok = ({1'b0, eoi_idx_i} < c_num_ext);
  assign w_set_idx_ok = ({1'b0, set_prio_idx_i} < c_num_ext);

  // Lowest-priority pointer: specific load takes precedence over EOI rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= c_last_idx;
    end else if (set_prio_i && w_mode == ROT_SPECIFIC && w_set_idx_ok) begin
      r_ptr <= set_prio_idx_i;
    end else if (eoi_i && w_mode == ROT_AUTO && w_eoi_idx_ok) begin
      r_ptr <= eoi_idx_i;
    end
  end

  // Request/acknowledge FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      int_req_o   <= 1'b0;
      int_idx_o   <= '0;
      ack_valid_o <= 1'b0;
      ack_idx_o   <= '0;
      spurious_o  <= 1'b0;
    end else begin
      ack_valid_o <= 1'b0;
      spurious_o  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid && !freeze_i) begin
            r_state   <= ST_REQ;
            int_req_o <= 1'b1;
            int_idx_o <= w_cand_idx;
          end
        end
        ST_REQ: begin
          if (w_win_valid) int_idx_o <= w_cand_idx;
          if (int_ack_i) begin
            r_state     <= ST_ACKED;
            int_req_o   <= 1'b0;
            ack_valid_o <= 1'b1;
            ack_idx_o   <= w_win_valid ? w_cand_idx : c_last_idx;
            spurious_o  <= ~w_win_valid;
          end
        end
        ST_ACKED: begin
          // One quiet cycle so the in-service register can catch up.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state   <= ST_IDLE;
          int_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
